light_safety_monitor: RTL

// Downstream stage of the traffic-light controller FSM. Takes the four 3-bit lamp codes (M1, M2, S, MT)
// and drives the physical lamp outputs. Each cycle it checks for illegal codes, conflicting greens and

---
 rtl/tl_pkg.sv | 31 +++
 rtl/flash_divider.sv | 28 ++
 rtl/light_safety_monitor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared lamp codes, fault causes and monitor state encoding for the traffic-light datapath.
package tl_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_AMB = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [2:0] {
    FLT_NONE     = 3'd0,
    FLT_ILLEGAL  = 3'd1,
    FLT_CONFLICT = 3'd2,
    FLT_SKIP     = 3'd3
  } fault_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_PASS,
    ST_FLASH
  } mon_state_t;

  function automatic logic is_onehot(input logic [2:0] code);
    return (code == LAMP_RED) || (code == LAMP_AMB) || (code == LAMP_GRN);
  endfunction

  // A head that is releasing traffic: green or amber.
  function automatic logic is_go(input logic [2:0] code);
    return (code == LAMP_AMB) || (code == LAMP_GRN);
  endfunction

endpackage

// File: rtl/flash_divider.sv
// Amber flash phase generator; phase_on is the phase the lamps take at the next enabled edge.
module flash_divider #(
  parameter int unsigned FLASH_HALF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_on
);

  localparam int unsigned CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(FLASH_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt      <= '0;
      phase_on <= 1'b1;
    end else if (cnt == HALF_LAST) begin
      cnt      <= '0;
      phase_on <= ~phase_on;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/light_safety_monitor.sv
// Safety stage between the light controller and the lamp drivers: filters illegal/conflicting
// codes, detects green->red skips and falls back to flashing amber on a fault.
module light_safety_monitor
  import tl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES   = 4,
  parameter int unsigned GLITCH_CYCLES = 2,
  parameter int unsigned FLASH_HALF    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1_in,
  input  logic [2:0] light_M2_in,
  input  logic [2:0] light_S_in,
  input  logic [2:0] light_MT_in,
  input  logic       clr_fault,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_S,
  output logic [2:0] lamp_MT,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam int unsigned GW = $clog2(GLITCH_CYCLES + 1);
  localparam logic [GW-1:0] GLITCH_MAX = GW'(GLITCH_CYCLES);

  mon_state_t state, state_n;
  logic [IW-1:0] init_cnt, init_cnt_n;
  logic [GW-1:0] ill_cnt, ill_cnt_n, con_cnt, con_cnt_n;
  logic [3:0][2:0] in_v, prev_v, prev_n, lamp_v, lamp_n;
  logic [3:0] ill_lane, go_lane, hold;
  logic illegal, conflict, skip, ill_trip, con_trip, inputs_ok, phase_on;
  logic [2:0] code_n;

  // Lane order: 0 = M1, 1 = M2, 2 = S, 3 = MT.
  assign in_v = {light_MT_in, light_S_in, light_M2_in, light_M1_in};
  assign {lamp_MT, lamp_S, lamp_M2, lamp_M1} = lamp_v;

  always_comb begin
    skip = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      ill_lane[i] = !is_onehot(in_v[i]);
      skip = skip | ((prev_v[i] == LAMP_GRN) && (in_v[i] == LAMP_RED));
    end
    illegal   = |ill_lane;
    go_lane   = {in_v[3] == LAMP_GRN, 1'b1, is_go(in_v[1]), is_go(in_v[0])};
    conflict  = is_go(in_v[2]) && (is_go(in_v[0]) || is_go(in_v[1]) || (in_v[3] == LAMP_GRN));
    inputs_ok = !illegal && !conflict;
    hold      = ill_lane | (conflict ? go_lane : '0);

    ill_cnt_n = '0;
    con_cnt_n = '0;
    if (state == ST_PASS && illegal)
      ill_cnt_n = (ill_cnt == GLITCH_MAX) ? ill_cnt : ill_cnt + 1'b1;
    if (state == ST_PASS && conflict)
      con_cnt_n = (con_cnt == GLITCH_MAX) ? con_cnt : con_cnt + 1'b1;
    ill_trip = (ill_cnt_n == GLITCH_MAX);
    con_trip = (con_cnt_n == GLITCH_MAX);
  end

  always_comb begin
    state_n    = state;
    code_n     = fault_code;
    init_cnt_n = '0;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) state_n = ST_PASS;
        else init_cnt_n = init_cnt + 1'b1;
      end
      ST_PASS: begin
        if (ill_trip || con_trip || skip) begin
          state_n = ST_FLASH;
          if (ill_trip)      code_n = FLT_ILLEGAL;
          else if (con_trip) code_n = FLT_CONFLICT;
          else               code_n = FLT_SKIP;
        end
      end
      ST_FLASH: begin
        if (clr_fault && inputs_ok) begin
          state_n = ST_INIT;
          code_n  = FLT_NONE;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  // Held lanes also keep their skip reference, so a suppressed glitch never looks like a skip.
  always_comb begin
    lamp_n = {4{LAMP_RED}};
    prev_n = in_v;
    if (state_n == ST_FLASH) begin
      lamp_n = {4{phase_on ? LAMP_AMB : LAMP_OFF}};
    end else if (state == ST_PASS) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (hold[i]) begin
          lamp_n[i] = lamp_v[i];
          prev_n[i] = prev_v[i];
        end else begin
          lamp_n[i] = in_v[i];
        end
      end
    end
  end

  flash_divider #(.FLASH_HALF(FLASH_HALF)) u_flash (
    .clk      (clk),
    .rst      (rst),
    .en       (state_n == ST_FLASH),
    .phase_on (phase_on)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      ill_cnt    <= '0;
      con_cnt    <= '0;
      prev_v     <= {4{LAMP_RED}};
      lamp_v     <= {4{LAMP_RED}};
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      state      <= state_n;
      init_cnt   <= init_cnt_n;
      ill_cnt    <= ill_cnt_n;
      con_cnt    <= con_cnt_n;
      prev_v     <= prev_n;
      lamp_v     <= lamp_n;
      fault      <= (state_n == ST_FLASH);
      fault_code <= code_n;
    end
  end

endmodule
